m_mig_ui_responder: RTL

//   BRAM-backed responder for the MIG 7-series user (app_*) interface. Drop-in stand-in for
//   mig_7series_0 on the controller side: the traffic-generator/initiator logic drives the

---
 rtl/m_mig_ui_responder.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/m_mig_ui_responder.sv
// m_mig_ui_responder
//   BRAM-backed stand-in for the MIG 7-series user (app_*) interface.
//   Models calibration delay, write command / write data pairing through a
//   one-entry command register and a two-entry data FIFO, byte-masked commits,
//   and in-order fixed-latency read return with an outstanding-read limit.
//   Optional build macro: REFRESH_STALL_EN adds periodic app_rdy refresh stalls.
module m_mig_ui_responder #(
   parameter int ADDR_WIDTH   = 28,
   parameter int DATA_WIDTH   = 128,
   parameter int MASK_WIDTH   = 16,
   parameter int DEPTH_LOG2   = 10,
   parameter int CALIB_CYCLES = 64,
   parameter int RD_LATENCY   = 4,
   parameter int RDQ_DEPTH    = 4,
   parameter int REF_INTERVAL = 780,
   parameter int REF_STALL    = 8
) (
   input  logic                  w_clk,
   input  logic                  sys_rst,
   input  logic [ADDR_WIDTH-1:0] app_addr,
   input  logic [2:0]            app_cmd,
   input  logic                  app_en,
   input  logic [DATA_WIDTH-1:0] app_wdf_data,
   input  logic [MASK_WIDTH-1:0] app_wdf_mask,
   input  logic                  app_wdf_wren,
   input  logic                  app_wdf_end,
   output logic                  app_rdy,
   output logic                  app_wdf_rdy,
   output logic [DATA_WIDTH-1:0] app_rd_data,
   output logic                  app_rd_data_valid,
   output logic                  app_rd_data_end,
   output logic                  init_calib_complete
);

   localparam int CW = $clog2(CALIB_CYCLES + 1);
   localparam int OW = $clog2(RDQ_DEPTH + 1);
   localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);
   localparam logic [OW-1:0] RDQ_MAX    = OW'(RDQ_DEPTH);

   // Calibration state
   logic [CW-1:0]         calib_cnt_q;
   logic                  calib_q;
   logic                  calib_nx;

   // Command decode
   logic [DEPTH_LOG2-1:0] cmd_idx;
   logic                  cmd_acc;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  wdf_acc;
   logic                  commit;
   logic                  rd_ret;

   // Pending write command
   logic                  wcmd_valid_q;
   logic                  wcmd_valid_nx;
   logic [DEPTH_LOG2-1:0] wcmd_idx_q;

   // Write data FIFO (2 entries)
   logic [DATA_WIDTH-1:0] fifo_data [0:1];
   logic [MASK_WIDTH-1:0] fifo_mask [0:1];
   logic                  fifo_wp_q;
   logic                  fifo_rp_q;
   logic [1:0]            fifo_cnt_q;
   logic [1:0]            fifo_cnt_nx;

   // Read tracking and return pipe
   logic [OW-1:0]         rd_out_q;
   logic [OW-1:0]         rd_out_nx;
   logic [RD_LATENCY-1:0] vld_p;
   logic [DATA_WIDTH-1:0] rd_data_p [0:RD_LATENCY-1];

   // Registered handshakes
   logic                  app_rdy_q;
   logic                  app_wdf_rdy_q;
   logic                  stall_nx;

   // Backing store
   logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   // Address bits outside the word index and the always-one end flag carry no information
   logic                  unused_sig;
   assign unused_sig = ^{app_wdf_end, app_addr[ADDR_WIDTH-1:DEPTH_LOG2+3], app_addr[2:0]};

   assign cmd_idx  = app_addr[DEPTH_LOG2+2:3];
   assign cmd_acc  = app_en && app_rdy_q;
   assign wr_acc   = cmd_acc && (app_cmd == 3'b000);
   assign rd_acc   = cmd_acc && (app_cmd == 3'b001);
   assign wdf_acc  = app_wdf_wren && app_wdf_rdy_q;
   assign commit   = wcmd_valid_q && (fifo_cnt_q != 2'd0);
   assign rd_ret   = vld_p[RD_LATENCY-1];
   assign calib_nx = calib_q || (calib_cnt_q == CALIB_LAST);

`ifdef REFRESH_STALL_EN
   localparam int RW = $clog2(REF_INTERVAL);
   localparam logic [RW-1:0] REF_LAST  = RW'(REF_INTERVAL - 1);
   localparam logic [RW-1:0] REF_START = RW'(REF_INTERVAL - REF_STALL);

   logic [RW-1:0] ref_cnt_q;
   logic [RW-1:0] ref_cnt_nx;

   // Refresh phase counter advances only once calibrated; stall occupies the last REF_STALL slots
   always_comb begin
      ref_cnt_nx = ref_cnt_q;
      if (calib_q) begin
         ref_cnt_nx = (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + RW'(1);
      end
   end

   assign stall_nx = calib_q && (ref_cnt_nx >= REF_START);

   // Refresh phase counter register
   always_ff @(posedge w_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ref_cnt_q <= '0;
      end else begin
         ref_cnt_q <= ref_cnt_nx;
      end
   end
`else
   localparam bit unused_ref_cfg = (REF_INTERVAL > REF_STALL);
   assign stall_nx = 1'b0;
`endif

   // Calibration counter: runs from reset release until the complete flag latches
   always_ff @(posedge w_clk or posedge sys_rst) begin
      if (sys_rst) begin
         calib_cnt_q <= '0;
         calib_q     <= 1'b0;
      end else if (!calib_q) begin
         calib_q <= calib_nx;
         if (!calib_nx) begin
            calib_cnt_q <= calib_cnt_q + CW'(1);
         end
      end
   end

   // Next-state of the write command slot, FIFO occupancy and outstanding reads
   always_comb begin
      wcmd_valid_nx = wcmd_valid_q;
      if (commit) wcmd_valid_nx = 1'b0;
      if (wr_acc) wcmd_valid_nx = 1'b1;

      fifo_cnt_nx = fifo_cnt_q;
      unique case ({wdf_acc, commit})
         2'b10:   fifo_cnt_nx = fifo_cnt_q + 2'd1;
         2'b01:   fifo_cnt_nx = fifo_cnt_q - 2'd1;
         default: fifo_cnt_nx = fifo_cnt_q;
      endcase

      rd_out_nx = rd_out_q;
      unique case ({rd_acc, rd_ret})
         2'b10:   rd_out_nx = rd_out_q + OW'(1);
         2'b01:   rd_out_nx = rd_out_q - OW'(1);
         default: rd_out_nx = rd_out_q;
      endcase
   end

   // Control registers; the ready flags are computed from next-state so they never
   // depend combinationally on app_en / app_wdf_wren
   always_ff @(posedge w_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wcmd_valid_q  <= 1'b0;
         fifo_wp_q     <= 1'b0;
         fifo_rp_q     <= 1'b0;
         fifo_cnt_q    <= 2'd0;
         rd_out_q      <= '0;
         app_rdy_q     <= 1'b0;
         app_wdf_rdy_q <= 1'b0;
      end else begin
         wcmd_valid_q  <= wcmd_valid_nx;
         fifo_cnt_q    <= fifo_cnt_nx;
         rd_out_q      <= rd_out_nx;
         if (wdf_acc) fifo_wp_q <= ~fifo_wp_q;
         if (commit)  fifo_rp_q <= ~fifo_rp_q;
         app_rdy_q     <= calib_nx && !wcmd_valid_nx && (rd_out_nx < RDQ_MAX) && !stall_nx;
         app_wdf_rdy_q <= calib_nx && (fifo_cnt_nx != 2'd2);
      end
   end

   // Write command address capture (data path, no reset)
   always_ff @(posedge w_clk) begin
      if (wr_acc) wcmd_idx_q <= cmd_idx;
   end

   // Write data FIFO storage (data path, no reset)
   always_ff @(posedge w_clk) begin
      if (wdf_acc) begin
         fifo_data[fifo_wp_q] <= app_wdf_data;
         fifo_mask[fifo_wp_q] <= app_wdf_mask;
      end
   end

   // Commit: write every byte whose mask bit is clear
   always_ff @(posedge w_clk) begin
      if (commit) begin
         for (int b = 0; b < MASK_WIDTH; b++) begin
            if (!fifo_mask[fifo_rp_q][b]) begin
               mem[wcmd_idx_q][b*8 +: 8] <= fifo_data[fifo_rp_q][b*8 +: 8];
            end
         end
      end
   end

   // ---- stage p0: synchronous BRAM read at accept; later stages only delay the word ----
   always_ff @(posedge w_clk) begin
      if (rd_acc) rd_data_p[0] <= mem[cmd_idx];
      for (int k = 1; k < RD_LATENCY; k++) begin
         rd_data_p[k] <= rd_data_p[k-1];
      end
   end

   // Read valid pipe travels alongside the data; cleared on reset to drop in-flight reads
   always_ff @(posedge w_clk or posedge sys_rst) begin
      if (sys_rst) begin
         vld_p <= '0;
      end else begin
         vld_p <= {vld_p[RD_LATENCY-2:0], rd_acc};
      end
   end

   // ---- output stage ----
   assign app_rdy             = app_rdy_q;
   assign app_wdf_rdy         = app_wdf_rdy_q;
   assign app_rd_data_valid   = rd_ret;
   assign app_rd_data_end     = rd_ret;
   assign app_rd_data         = rd_ret ? rd_data_p[RD_LATENCY-1] : '0;
   assign init_calib_complete = calib_q;

endmodule
